// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, EX-resolved branches/jumps and multi-cycle
// data-memory accesses. It also keeps saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [1:0]  LOAD_SEL = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       rf_wd_sel_ex,
    input  logic             rf_we_ex,
    input  logic [4:0]       rf_wa_ex,
    input  logic             rf_re0_id,
    input  logic             rf_re1_id,
    input  logic [4:0]       rf_ra0_id,
    input  logic [4:0]       rf_ra1_id,
    input  logic             npc_sel_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic lu;
    logic mw;
    logic freeze;
    logic branch_act;

    // Hazard terms: load-use the forwarding path cannot cover, and an unacked memory access
    always_comb begin
        lu = (rf_wd_sel_ex == LOAD_SEL) && rf_we_ex && (rf_wa_ex != 5'd0) &&
             ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
              (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
        mw     = dmem_req_mem && !dmem_ack;
        freeze = mw || ((state == S_WAIT) && !dmem_ack);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: wait for the data-memory ack
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (mw)       state_nxt = S_WAIT;
            S_WAIT:  if (dmem_ack) state_nxt = S_RUN;
            default:               state_nxt = S_RUN;
        endcase
    end

    // Output decode by priority: memory freeze, branch flush, load-use bubble
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        branch_act   = 1'b0;
        if (!rst) begin
            if (freeze) begin
                // Hold everything up to EX/MEM; a held branch or load-use is acted on later
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (npc_sel_ex) begin
                // The ID instruction is discarded, so a coincident load-use is moot
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                branch_act  = 1'b1;
            end else if (lu) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    assign mem_busy = (state == S_WAIT);

    // Saturating debug counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_act && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
